// File: rtl/uart_cmd_pkg.sv
// -----------------------------------------------------------------------------
// uart_cmd_pkg
// Shared constants and types for the serial command receiver:
//   - frame header byte and command id codes
//   - maximum legal value per command class (hour / minute-second / light)
//   - byte receiver and frame parser state encodings
//   - cmd_acceptable(): the complete validity test for a received frame
// Optional feature macro: UART_RX_PARITY_EN (adds the RX_PARITY state).
// -----------------------------------------------------------------------------
package uart_cmd_pkg;

    localparam logic [7:0] FRAME_HDR    = 8'hA5;

    localparam logic [7:0] CMD_CUR_HOUR = 8'd1;
    localparam logic [7:0] CMD_CUR_MIN  = 8'd2;
    localparam logic [7:0] CMD_CUR_SEC  = 8'd3;
    localparam logic [7:0] CMD_HOUR_THR = 8'd4;
    localparam logic [7:0] CMD_MIN_THR  = 8'd5;
    localparam logic [7:0] CMD_SEC_THR  = 8'd6;
    localparam logic [7:0] CMD_LIGHT    = 8'd7;

    localparam logic [5:0] MAX_HOUR     = 6'd23;
    localparam logic [5:0] MAX_MIN_SEC  = 6'd59;
    localparam logic [5:0] MAX_LIGHT    = 6'd1;

    typedef enum logic [1:0] {
        P_HUNT,
        P_GOT_HDR,
        P_GOT_ID,
        P_GOT_VAL
    } parser_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_RX_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    // A frame is accepted only if the checksum matches, the id is one of the
    // seven known commands and the value fits the 6-bit field and its range.
    function automatic logic cmd_acceptable(input logic [7:0] id,
                                            input logic [7:0] value,
                                            input logic [7:0] chk);
        logic [5:0] max_v;
        logic       legal;
        max_v = 6'd0;
        legal = 1'b1;
        case (id)
            CMD_CUR_HOUR, CMD_HOUR_THR:                        max_v = MAX_HOUR;
            CMD_CUR_MIN, CMD_CUR_SEC, CMD_MIN_THR, CMD_SEC_THR: max_v = MAX_MIN_SEC;
            CMD_LIGHT:                                          max_v = MAX_LIGHT;
            default:                                            legal = 1'b0;
        endcase
        return legal && (chk == (id ^ value)) && (value[7:6] == 2'b00)
               && (value[5:0] <= max_v);
    endfunction

endpackage

// File: rtl/uart_rx_cmd_if.sv
// -----------------------------------------------------------------------------
// uart_rx_cmd_if
// Bundles the serial input and all receiver/command outputs.
//   slave  : the receiver side (consumes rx, drives the strobes and data)
//   master : the host/controller side (drives rx, observes the outputs)
// Signals: rx, byte_valid, byte_data[7:0], cmd_valid, cmd_id[3:0],
//          cmd_value[5:0], frame_err, cmd_err, busy.
// -----------------------------------------------------------------------------
interface uart_rx_cmd_if;

    logic       rx;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       cmd_valid;
    logic [3:0] cmd_id;
    logic [5:0] cmd_value;
    logic       frame_err;
    logic       cmd_err;
    logic       busy;

    modport slave (
        input  rx,
        output byte_valid, byte_data, cmd_valid, cmd_id, cmd_value,
               frame_err, cmd_err, busy
    );

    modport master (
        output rx,
        input  byte_valid, byte_data, cmd_valid, cmd_id, cmd_value,
               frame_err, cmd_err, busy
    );

endinterface

// File: rtl/uart_rx_byte.sv
// -----------------------------------------------------------------------------
// uart_rx_byte
// Serial byte receiver: 2-flop synchronizer, start-bit glitch rejection,
// LSB-first data capture, stop-bit check and break handling.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   rx          : asynchronous serial input, idle high
//   byte_valid  : one-cycle pulse, byte with good framing received
//   byte_data   : last good byte, held until the next byte_valid
//   frame_err   : one-cycle pulse, bad stop (or parity) bit
//   busy        : receiver not in RX_IDLE
// Optional feature macro: UART_RX_PARITY_EN (even parity bit before stop).
// -----------------------------------------------------------------------------
module uart_rx_byte
    import uart_cmd_pkg::*;
#(
    parameter int unsigned DIVISOR = 10416
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned     CNT_W     = $clog2(DIVISOR + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIVISOR / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(DIVISOR - 1);

    // Synchronizer chain, preset to the idle level so reset never looks like
    // a start bit.
    logic [1:0] sync_reg;
    logic       rx_s;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) sync_reg[gi] <= 1'b1;
                    else     sync_reg[gi] <= rx;
                end
            end else begin : g_next
                always_ff @(posedge clk) begin
                    if (rst) sync_reg[gi] <= 1'b1;
                    else     sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign rx_s = sync_reg[1];

    rx_state_t        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic [7:0]       shift_reg, shift_next;
    logic [7:0]       byte_data_reg, byte_data_next;
    logic             byte_valid_reg, byte_valid_next;
    logic             frame_err_reg, frame_err_next;
    logic             parity_bad;

`ifdef UART_RX_PARITY_EN
    logic parity_bad_reg, parity_bad_next;

    always_ff @(posedge clk) begin
        if (rst) parity_bad_reg <= 1'b0;
        else     parity_bad_reg <= parity_bad_next;
    end

    assign parity_bad = parity_bad_reg;
`else
    assign parity_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= RX_IDLE;
            cnt_reg        <= '0;
            bit_idx_reg    <= 3'd0;
            shift_reg      <= 8'h00;
            byte_data_reg  <= 8'h00;
            byte_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            bit_idx_reg    <= bit_idx_next;
            shift_reg      <= shift_next;
            byte_data_reg  <= byte_data_next;
            byte_valid_reg <= byte_valid_next;
            frame_err_reg  <= frame_err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        bit_idx_next    = bit_idx_reg;
        shift_next      = shift_reg;
        byte_data_next  = byte_data_reg;
        byte_valid_next = 1'b0;
        frame_err_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bad_next = parity_bad_reg;
`endif
        case (state_reg)
            RX_IDLE: begin
                if (!rx_s) begin
                    cnt_next   = '0;
                    state_next = RX_START;
                end
            end
            // Re-check the line half a bit later: a short low pulse is noise.
            RX_START: begin
                if (cnt_reg == HALF_LAST) begin
                    cnt_next     = '0;
                    bit_idx_next = 3'd0;
                    state_next   = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_reg == FULL_LAST) begin
                    cnt_next     = '0;
                    shift_next   = {rx_s, shift_reg[7:1]};
                    bit_idx_next = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = RX_PARITY;
`else
                        state_next = RX_STOP;
`endif
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            // Even parity: data ones plus parity bit must be even.
            RX_PARITY: begin
                if (cnt_reg == FULL_LAST) begin
                    cnt_next        = '0;
                    parity_bad_next = rx_s ^ (^shift_reg);
                    state_next      = RX_STOP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
`endif
            RX_STOP: begin
                if (cnt_reg == FULL_LAST) begin
                    cnt_next = '0;
                    if (rx_s && !parity_bad) begin
                        byte_valid_next = 1'b1;
                        byte_data_next  = shift_reg;
                    end else begin
                        frame_err_next = 1'b1;
                    end
                    state_next = rx_s ? RX_IDLE : RX_BREAK;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            // A line held low must return high before another start is seen.
            RX_BREAK: begin
                if (rx_s) state_next = RX_IDLE;
            end
            default: state_next = RX_IDLE;
        endcase
    end

    assign byte_valid = byte_valid_reg;
    assign byte_data  = byte_data_reg;
    assign frame_err  = frame_err_reg;
    assign busy       = (state_reg != RX_IDLE);

endmodule

// File: rtl/uart_rx_cmd.sv
// -----------------------------------------------------------------------------
// uart_rx_cmd
// Receives 4-byte command frames (0xA5, ID, VALUE, CHK = ID ^ VALUE) over an
// 8N1 serial line and issues one-cycle command strobes.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : uart_rx_cmd_if.slave -- rx in; byte_valid, byte_data,
//              cmd_valid, cmd_id, cmd_value, frame_err, cmd_err, busy out
// Parameters: CLK_FREQ, BAUD_RATE (DIVISOR derived), TIMEOUT_BITS.
// Optional feature macro: UART_RX_PARITY_EN (even parity, in uart_rx_byte).
// -----------------------------------------------------------------------------
module uart_rx_cmd
    import uart_cmd_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 100000000,
    parameter int unsigned BAUD_RATE    = 9600,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_cmd_if.slave   bus
);

    localparam int unsigned      DIVISOR  = CLK_FREQ / BAUD_RATE;
    localparam int unsigned      TO_LIMIT = TIMEOUT_BITS * DIVISOR;
    localparam int unsigned      TO_W     = $clog2(TO_LIMIT + 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_LIMIT - 1);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;
    logic       busy;

    uart_rx_byte #(
        .DIVISOR (DIVISOR)
    ) u_byte (
        .clk        (clk),
        .rst        (rst),
        .rx         (bus.rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    parser_state_t   p_state_reg, p_state_next;
    logic [7:0]      id_reg, id_next;
    logic [7:0]      val_reg, val_next;
    logic            cmd_valid_reg, cmd_valid_next;
    logic            cmd_err_reg, cmd_err_next;
    logic [3:0]      cmd_id_reg, cmd_id_next;
    logic [5:0]      cmd_value_reg, cmd_value_next;
    logic [TO_W-1:0] idle_cnt_reg, idle_cnt_next;
    logic            timeout_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            p_state_reg   <= P_HUNT;
            id_reg        <= 8'h00;
            val_reg       <= 8'h00;
            cmd_valid_reg <= 1'b0;
            cmd_err_reg   <= 1'b0;
            cmd_id_reg    <= 4'd0;
            cmd_value_reg <= 6'd0;
            idle_cnt_reg  <= '0;
        end else begin
            p_state_reg   <= p_state_next;
            id_reg        <= id_next;
            val_reg       <= val_next;
            cmd_valid_reg <= cmd_valid_next;
            cmd_err_reg   <= cmd_err_next;
            cmd_id_reg    <= cmd_id_next;
            cmd_value_reg <= cmd_value_next;
            idle_cnt_reg  <= idle_cnt_next;
        end
    end

    // The gap counter only measures line silence inside a frame; any byte
    // in flight (receiver busy) restarts it.
    assign timeout_hit = (p_state_reg != P_HUNT) && !busy && (idle_cnt_reg == TO_LAST);

    always_comb begin
        p_state_next   = p_state_reg;
        id_next        = id_reg;
        val_next       = val_reg;
        cmd_valid_next = 1'b0;
        cmd_err_next   = 1'b0;
        cmd_id_next    = cmd_id_reg;
        cmd_value_next = cmd_value_reg;

        if (p_state_reg == P_HUNT || busy || timeout_hit) idle_cnt_next = '0;
        else                                               idle_cnt_next = idle_cnt_reg + 1'b1;

        if (frame_err) begin
            p_state_next = P_HUNT;
        end else if (byte_valid) begin
            case (p_state_reg)
                P_HUNT: begin
                    if (byte_data == FRAME_HDR) p_state_next = P_GOT_HDR;
                end
                P_GOT_HDR: begin
                    id_next      = byte_data;
                    p_state_next = P_GOT_ID;
                end
                P_GOT_ID: begin
                    val_next     = byte_data;
                    p_state_next = P_GOT_VAL;
                end
                P_GOT_VAL: begin
                    if (cmd_acceptable(id_reg, val_reg, byte_data)) begin
                        cmd_valid_next = 1'b1;
                        cmd_id_next    = id_reg[3:0];
                        cmd_value_next = val_reg[5:0];
                    end else begin
                        cmd_err_next = 1'b1;
                    end
                    p_state_next = P_HUNT;
                end
                default: p_state_next = P_HUNT;
            endcase
        end else if (timeout_hit) begin
            p_state_next = P_HUNT;
        end
    end

    assign bus.byte_valid = byte_valid;
    assign bus.byte_data  = byte_data;
    assign bus.frame_err  = frame_err;
    assign bus.busy       = busy;
    assign bus.cmd_valid  = cmd_valid_reg;
    assign bus.cmd_err    = cmd_err_reg;
    assign bus.cmd_id     = cmd_id_reg;
    assign bus.cmd_value  = cmd_value_reg;

endmodule

// File: tb/tb_uart_rx_cmd.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_cmd
// Self-checking bench for uart_rx_cmd, run at a reduced bit rate
// (16 clocks per bit) so whole frames fit in a short simulation.
// Builds with or without UART_RX_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_uart_rx_cmd;

    localparam int DIV     = 16;
    localparam int TO_BITS = 20;

    typedef struct packed {
        logic       is_err;
        logic [3:0] id;
        logic [5:0] val;
        logic       lag_ok;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_rx_cmd_if bus_if ();

    uart_rx_cmd #(
        .CLK_FREQ     (1600),
        .BAUD_RATE    (100),
        .TIMEOUT_BITS (TO_BITS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Observed events, captured away from the active edge.
    logic [7:0] byte_q[$];
    ev_t        cmd_q[$];
    ev_t        exp_q[$];
    int         ferr_cnt    = 0;
    int         overlap_cnt = 0;
    logic       bv_prev     = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus_if.byte_valid) byte_q.push_back(bus_if.byte_data);
            if (bus_if.frame_err) ferr_cnt++;
            if (bus_if.cmd_valid || bus_if.cmd_err)
                cmd_q.push_back(ev_t'{bus_if.cmd_err, bus_if.cmd_id, bus_if.cmd_value, bv_prev});
            if (bus_if.byte_valid && (bus_if.cmd_valid || bus_if.cmd_err)) overlap_cnt++;
            if (bus_if.cmd_valid && bus_if.cmd_err) overlap_cnt++;
        end
        bv_prev = bus_if.byte_valid;
    end

    initial begin
        #900000;
        $display("FAIL watchdog sim_time=%0t limit=900000", $time);
        $fatal(1, "watchdog expired");
    end

    // Reference: scan the byte stream, each 0xA5 in hunt mode opens a frame of
    // the next three bytes; the frame is good when CHK = ID ^ VALUE and VALUE
    // does not exceed the maximum for a known id.
    function automatic void model_stream(input logic [7:0] s[$]);
        int         max_tab[8] = '{0, 23, 59, 59, 23, 59, 59, 1};
        int         i;
        logic [7:0] id, v, c;
        bit         ok;
        i = 0;
        while (i < s.size()) begin
            if (s[i] == 8'hA5 && i + 3 < s.size()) begin
                id = s[i+1];
                v  = s[i+2];
                c  = s[i+3];
                ok = (id >= 1) && (id <= 7) && (int'(v) <= max_tab[id[2:0]]) && (c == (id ^ v));
                exp_q.push_back(ev_t'{!ok, ok ? id[3:0] : 4'd0, ok ? v[5:0] : 6'd0, 1'b1});
                i += 4;
            end else begin
                i++;
            end
        end
    endfunction

    task automatic clear_logs();
        byte_q.delete();
        cmd_q.delete();
        exp_q.delete();
        ferr_cnt    = 0;
        overlap_cnt = 0;
    endtask

    task automatic idle_bits(input int n);
        bus_if.rx = 1'b1;
        repeat (n * DIV) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_val = 1'b1,
                             input bit par_flip = 1'b0);
        bus_if.rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            bus_if.rx = b[k];
            repeat (DIV) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        bus_if.rx = (^b) ^ par_flip;
        repeat (DIV) @(negedge clk);
`else
        if (par_flip) $display("note: no parity bit in this build");
`endif
        bus_if.rx = stop_val;
        repeat (DIV) @(negedge clk);
        bus_if.rx = 1'b1;
    endtask

    task automatic send_stream(input string tag, input logic [7:0] s[$], input int gap_bits);
        $display("tx %s: %0d bytes", tag, s.size());
        foreach (s[i]) begin
            send_byte(s[i]);
            if (gap_bits > 0) idle_bits(gap_bits);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [27:0] outs;
        rst       = 1'b1;
        bus_if.rx = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            outs = {bus_if.byte_valid, bus_if.byte_data, bus_if.cmd_valid, bus_if.cmd_id,
                    bus_if.cmd_value, bus_if.frame_err, bus_if.cmd_err, bus_if.busy};
            checks++;
            if (outs !== 28'd0) begin
                failures++;
                $display("FAIL reset_outputs cycle=%0d got=%h exp=0", i, outs);
            end
        end
        $display("reset: 100 idle cycles observed");
    endtask

    task automatic test_basic();
        logic [7:0] s[$];
        clear_logs();
        s = '{8'hA5, 8'h02, 8'h1E, 8'h1C};
        send_stream("basic", s, 0);
        checks++;
        if (byte_q.size() != 4 || byte_q[3] !== 8'h1C) begin
            failures++;
            $display("FAIL basic_bytes got_n=%0d exp_n=4", byte_q.size());
        end
        checks++;
        if (cmd_q.size() != 1) begin
            failures++;
            $display("FAIL basic_count got=%0d exp=1", cmd_q.size());
        end else begin
            checks++;
            if (cmd_q[0] !== ev_t'{1'b0, 4'd2, 6'd30, 1'b1}) begin
                failures++;
                $display("FAIL basic_cmd got=%h exp=%h", cmd_q[0], ev_t'{1'b0, 4'd2, 6'd30, 1'b1});
            end
        end
    endtask

    task automatic test_range();
        logic [7:0] s[$];
        clear_logs();
        s = '{8'hA5, 8'h01, 8'h18, 8'h19, 8'hA5, 8'h07, 8'h01, 8'h06};
        send_stream("range", s, 1);
        checks++;
        if (cmd_q.size() != 2) begin
            failures++;
            $display("FAIL range_count got=%0d exp=2", cmd_q.size());
        end else begin
            checks++;
            if (cmd_q[0].is_err !== 1'b1 || cmd_q[0].lag_ok !== 1'b1) begin
                failures++;
                $display("FAIL range_hour24 got_err=%0b exp_err=1", cmd_q[0].is_err);
            end
            checks++;
            if (cmd_q[1] !== ev_t'{1'b0, 4'd7, 6'd1, 1'b1}) begin
                failures++;
                $display("FAIL range_light got=%h exp=%h", cmd_q[1], ev_t'{1'b0, 4'd7, 6'd1, 1'b1});
            end
        end
    endtask

    task automatic test_checksum_hunt();
        logic [7:0] s[$];
        clear_logs();
        s = '{8'hA5, 8'h03, 8'h10, 8'h00, 8'h55, 8'hA5, 8'h05, 8'h2D, 8'h28};
        send_stream("checksum", s, 0);
        checks++;
        if (cmd_q.size() != 2) begin
            failures++;
            $display("FAIL chk_count got=%0d exp=2", cmd_q.size());
        end else begin
            checks++;
            if (cmd_q[0].is_err !== 1'b1) begin
                failures++;
                $display("FAIL chk_bad got_err=%0b exp_err=1", cmd_q[0].is_err);
            end
            checks++;
            if (cmd_q[1] !== ev_t'{1'b0, 4'd5, 6'd45, 1'b1}) begin
                failures++;
                $display("FAIL chk_min_thr got=%h exp=%h", cmd_q[1], ev_t'{1'b0, 4'd5, 6'd45, 1'b1});
            end
        end
    endtask

    task automatic test_timeout();
        logic [7:0] s[$];
        clear_logs();
        s = '{8'hA5, 8'h04};
        send_stream("timeout_head", s, 0);
        idle_bits(TO_BITS + 5);
        s = '{8'h0C, 8'h08};
        send_stream("timeout_tail", s, 0);
        checks++;
        if (cmd_q.size() != 0 || byte_q.size() != 4) begin
            failures++;
            $display("FAIL timeout_resync got_cmds=%0d exp=0 got_bytes=%0d exp=4",
                     cmd_q.size(), byte_q.size());
        end
        // A gap well below the limit must keep the frame alive.
        clear_logs();
        s = '{8'hA5, 8'h05};
        send_stream("gap_head", s, 0);
        idle_bits(TO_BITS - 5);
        s = '{8'h2D, 8'h28};
        send_stream("gap_tail", s, 0);
        checks++;
        if (cmd_q.size() != 1 || cmd_q[0] !== ev_t'{1'b0, 4'd5, 6'd45, 1'b1}) begin
            failures++;
            $display("FAIL timeout_short_gap got_n=%0d exp_n=1", cmd_q.size());
        end
    endtask

    task automatic test_glitch();
        clear_logs();
        $display("tx glitch: 5-clock low pulse");
        bus_if.rx = 1'b0;
        repeat (5) @(negedge clk);
        bus_if.rx = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        checks++;
        if (byte_q.size() != 0 || ferr_cnt != 0 || bus_if.busy !== 1'b0) begin
            failures++;
            $display("FAIL glitch got_bytes=%0d got_ferr=%0d got_busy=%0b exp=0/0/0",
                     byte_q.size(), ferr_cnt, bus_if.busy);
        end
    endtask

    task automatic test_frame_err();
        logic [7:0] s[$];
        clear_logs();
        s = '{8'hA5, 8'h06};
        send_stream("ferr_head", s, 0);
        $display("tx ferr: byte 0A with stop=0");
        send_byte(8'h0A, 1'b0);
        idle_bits(1);
        s = '{8'h0A, 8'h0C};
        send_stream("ferr_tail", s, 0);
        checks++;
        if (ferr_cnt != 1) begin
            failures++;
            $display("FAIL ferr_count got=%0d exp=1", ferr_cnt);
        end
        checks++;
        if (cmd_q.size() != 0 || byte_q.size() != 4) begin
            failures++;
            $display("FAIL ferr_hunt got_cmds=%0d exp=0 got_bytes=%0d exp=4",
                     cmd_q.size(), byte_q.size());
        end
`ifdef UART_RX_PARITY_EN
        clear_logs();
        $display("tx parity: byte 03 with flipped parity");
        send_byte(8'h03, 1'b1, 1'b1);
        idle_bits(2);
        checks++;
        if (ferr_cnt != 1 || byte_q.size() != 0) begin
            failures++;
            $display("FAIL parity_err got_ferr=%0d exp=1 got_bytes=%0d exp=0",
                     ferr_cnt, byte_q.size());
        end
`endif
    endtask

    task automatic test_reset_midframe();
        logic [7:0]  s[$];
        logic [27:0] outs;
        s = '{8'hA5, 8'h02};
        send_stream("midreset_head", s, 0);
        bus_if.rx = 1'b0;
        repeat (3 * DIV) @(negedge clk);
        rst       = 1'b1;
        bus_if.rx = 1'b1;
        @(negedge clk);
        outs = {bus_if.byte_valid, bus_if.byte_data, bus_if.cmd_valid, bus_if.cmd_id,
                bus_if.cmd_value, bus_if.frame_err, bus_if.cmd_err, bus_if.busy};
        checks++;
        if (outs !== 28'd0) begin
            failures++;
            $display("FAIL midreset_outputs got=%h exp=0", outs);
        end
        rst = 1'b0;
        clear_logs();
        s = '{8'h1E, 8'h1C};
        send_stream("midreset_tail", s, 0);
        checks++;
        if (cmd_q.size() != 0 || byte_q.size() != 2) begin
            failures++;
            $display("FAIL midreset_abort got_cmds=%0d exp=0 got_bytes=%0d exp=2",
                     cmd_q.size(), byte_q.size());
        end
    endtask

    task automatic test_random();
        logic [7:0] s[$];
        logic [7:0] id, v, c, junk;
        int         max_tab[8] = '{0, 23, 59, 59, 23, 59, 59, 1};
        clear_logs();
        for (int f = 0; f < 24; f++) begin
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                junk = 8'($urandom_range(0, 255));
                if (junk == 8'hA5) junk = 8'h5A;
                s.push_back(junk);
            end
            id = 8'($urandom_range(0, 9));
            if ($urandom_range(0, 3) != 0 && id >= 1 && id <= 7)
                v = 8'($urandom_range(0, max_tab[id[2:0]]));
            else
                v = 8'($urandom_range(0, 255));
            c = id ^ v;
            if ($urandom_range(0, 5) == 0) c = c ^ 8'($urandom_range(1, 255));
            s.push_back(8'hA5);
            s.push_back(id);
            s.push_back(v);
            s.push_back(c);
        end
        model_stream(s);
        $display("tx random: %0d bytes, %0d frames expected", s.size(), exp_q.size());
        foreach (s[i]) begin
            send_byte(s[i]);
            idle_bits(int'($urandom_range(0, 3)));
        end
        repeat (4) @(negedge clk);
        checks++;
        if (byte_q != s) begin
            failures++;
            $display("FAIL random_bytes got_n=%0d exp_n=%0d", byte_q.size(), s.size());
        end
        checks++;
        if (cmd_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL random_count got=%0d exp=%0d", cmd_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < cmd_q.size(); i++) begin
            checks++;
            if (exp_q[i].is_err ? ({cmd_q[i].is_err, cmd_q[i].lag_ok} !== 2'b11)
                                : (cmd_q[i] !== exp_q[i])) begin
                failures++;
                $display("FAIL random_cmd idx=%0d got=%h exp=%h", i, cmd_q[i], exp_q[i]);
            end
        end
        checks++;
        if (overlap_cnt != 0) begin
            failures++;
            $display("FAIL pulse_overlap got=%0d exp=0", overlap_cnt);
        end
    endtask

    initial begin
        bus_if.rx = 1'b1;
        test_reset();
        test_basic();
        test_range();
        test_checksum_hunt();
        test_timeout();
        test_glitch();
        test_frame_err();
        test_reset_midframe();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
